// File: rtl/exec_datapath.sv
// Multi-cycle execute datapath: 32x64 register file, 8-op ALU and an
// IDLE -> EXEC -> WRITE sequencer with fixed two-edge latency.
module exec_datapath (
   input  logic        CLK,
   input  logic        RST,
   input  logic        reset_wire,
   input  logic [2:0]  operacao,
   input  logic        writeReg,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [63:0] imm,
   input  logic [4:0]  dbg_addr,
   output logic [63:0] dbg_data,
   output logic [63:0] alu_result,
   output logic        zero,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StExec, StWrite} state_e;

   state_e      state_q, state_d;
   logic [63:0] rf_q [32];
   logic [2:0]  op_q;
   logic [4:0]  rd_q;
   logic [63:0] imm_q, a_q, b_q;
   logic [63:0] alu_q;
   logic        zero_q;
   logic [63:0] alu_res;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (reset_wire) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (writeReg) state_d = StExec;
            StExec:  state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      alu_res = '0;
      unique case (op_q)
         3'b000: alu_res = imm_q;
         3'b001: alu_res = a_q + b_q;
         3'b010: alu_res = a_q - b_q;
         3'b011: alu_res = a_q & b_q;
         3'b100: alu_res = a_q | b_q;
         3'b101: alu_res = a_q ^ b_q;
         3'b110: alu_res = {63'd0, $signed(a_q) < $signed(b_q)};
         3'b111: alu_res = a_q << b_q[5:0];
         default: alu_res = '0;
      endcase
   end

   // reset_wire clears everything like RST, except zero goes to 0 instead of 1
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
         op_q   <= '0;
         rd_q   <= '0;
         imm_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         alu_q  <= '0;
         zero_q <= 1'b1;
      end else if (reset_wire) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
         op_q   <= '0;
         rd_q   <= '0;
         imm_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         alu_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (writeReg) begin
                  op_q  <= operacao;
                  rd_q  <= rd;
                  imm_q <= imm;
                  a_q   <= rf_q[rs1];
                  b_q   <= rf_q[rs2];
               end
            end
            StExec: begin
               alu_q  <= alu_res;
               zero_q <= (alu_res == 64'd0);
            end
            StWrite: begin
               if (rd_q != 5'd0) rf_q[rd_q] <= alu_q;
            end
            default: ;
         endcase
      end
   end

   assign dbg_data   = (dbg_addr == 5'd0) ? 64'd0 : rf_q[dbg_addr];
   assign alu_result = alu_q;
   assign zero       = zero_q;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StWrite);

endmodule

// File: doc/exec_datapath.md
EXEC_DATAPATH -- requirements
Module: exec_datapath

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port reset_wire, input, 1 bit: synchronous clear command from the control unit.
REQ-004 The block SHALL have the port operacao, input, 3 bits: ALU operation code.
REQ-005 The block SHALL have the port writeReg, input, 1 bit: execute-and-write request.
REQ-006 The block SHALL have the ports rs1, rs2 and rd, input, 5 bits each: source and destination register indices.
REQ-007 The block SHALL have the port imm, input, 64 bits: immediate operand for op 000.
REQ-008 The block SHALL have the port dbg_addr, input, 5 bits: debug read index.
REQ-009 The block SHALL have the port dbg_data, output, 64 bits: combinational read of regfile[dbg_addr]; 0 when dbg_addr=0.
REQ-010 The block SHALL have the port alu_result, output, 64 bits: registered last ALU result.
REQ-011 The block SHALL have the port zero, output, 1 bit: registered flag, alu_result==0.
REQ-012 The block SHALL have the port busy, output, 1 bit: high in EXEC and WRITE.
REQ-013 The block SHALL have the port done, output, 1 bit: one-cycle pulse in WRITE.

Function
REQ-014 The block SHALL contain a 32 x 64-bit register file; x0 SHALL read 0 always, and writes to x0 SHALL be discarded.
REQ-015 The FSM SHALL have exactly the states IDLE, EXEC and WRITE.
REQ-016 IDLE: when writeReg=1, the block SHALL latch operacao, rd, imm, regfile[rs1] into A and regfile[rs2] into B, then move to EXEC; when writeReg=0 it SHALL stay in IDLE.
REQ-017 EXEC: the block SHALL compute the ALU result into alu_result, update zero, and move to WRITE.
REQ-018 WRITE: the block SHALL write alu_result to regfile[latched rd] when rd≠0, assert done=1 for this single cycle, and move to IDLE.
REQ-019 Latency SHALL be fixed: a request sampled at edge N SHALL update alu_result at edge N+1 and write the register file at edge N+2; done SHALL be high for the whole cycle between edges N+1 and N+2.
REQ-020 writeReg SHALL be ignored while busy=1; requests are not queued.
REQ-021 Op 000 SHALL produce imm.
REQ-022 Op 001 SHALL produce A+B.
REQ-023 Op 010 SHALL produce A−B.
REQ-024 Op 011 SHALL produce A&B.
REQ-025 Op 100 SHALL produce A|B.
REQ-026 Op 101 SHALL produce A^B.
REQ-027 Op 110 SHALL produce 1 if A is less than B as signed values, else 0.
REQ-028 Op 111 SHALL produce A<<B[5:0].
REQ-029 Addition and subtraction SHALL wrap modulo 2^64, with no carry or overflow output.
REQ-030 Operands SHALL be read in IDLE at the request edge; a register written at that same edge SHALL NOT be forwarded, so the operand read is the old value.
REQ-031 A back-to-back request whose rs equals the previous rd SHALL read the new value, since the earliest next request is sampled after WRITE completes.
REQ-032 reset_wire=1, sampled at any rising edge in any state, SHALL take priority over writeReg and over a pending write.
REQ-033 On reset_wire=1 the block SHALL clear all registers, alu_result and zero and enter IDLE; the in-flight operation SHALL be aborted with no regfile write and no done pulse.

Reset
REQ-034 On RST=1 the block SHALL asynchronously set the state to IDLE, every register file entry to 0, alu_result to 0, zero to 1, busy to 0 and done to 0.
REQ-035 After RST deasserts, the first request SHALL be accepted at the first rising edge with writeReg=1.

Verification
REQ-036 Immediate load: op 000, imm=5, rd=1 -> alu_result=5 at edge N+1, done pulse, dbg_addr=1 reads 5; repeat with imm=7, rd=2 -> dbg_addr=2 reads 7.
REQ-037 Add and zero flag: x1=5, x2=7, op 001, rs1=1, rs2=2, rd=3 -> x3=12, zero=0; then op 010, rs1=3, rs2=3 -> result 0, zero=1.
REQ-038 Wrap and signed compare: x1=0xFFFF_FFFF_FFFF_FFFF, x2=1, op 001 -> 0, zero=1; op 110, rs1=1, rs2=2 -> 1, since −1 < 1.
REQ-039 x0 and busy: op 000, imm=9, rd=0 -> dbg_addr=0 reads 0; a writeReg pulse during EXEC -> ignored, exactly one done pulse.
REQ-040 Reset mid-operation: reset_wire=1 in EXEC -> no done, all registers read 0, state IDLE; RST asserted asynchronously mid-WRITE -> outputs immediately at reset values.
